sseg_scan_capture: RTL and testbench
====================================

# sseg_scan_capture

Monitors a multiplexed seven-segment display bus (active-low anode selects plus an active-high cathode pattern) and recovers the displayed hexadecimal value. It performs the inverse mapping of the team's seven-segment decoder and reassembles a full multi-digit frame from the time-multiplexed scan. It sits beside the display scanner as a self-check and readback path: a scoreboard or a register interface can read what is actually shown on the display.

## Interface
Parameters:
- DIGITS, 4: number of multiplexed digits; anode width.
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is captured (range 1..255).

Ports:
- clk  input  1  system clock; one clock domain only.
- rst_n  input  1  synchronous, active-low reset.
- anode  input  DIGITS  digit selects, active low; anode[k]=0 selects digit k.
- cathode  input  8  segment pattern, active high, bit order {dp,g,f,e,d,c,b,a}.
- value  output  4*DIGITS  recovered frame; digit k occupies value[4k+3:4k].
- dp_out  output  DIGITS  decimal-point state per digit, latched with value.
- digit_err  output  DIGITS  1 = the digit's segment pattern was not a legal hex glyph; latched with value.
- frame_valid  output  1  single-cycle pulse; value, dp_out and digit_err were updated on the same edge.

## Operation
- Glyph table, cathode[6:0] to nibble: 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F. Any other pattern is illegal: nibble 0 and the error bit set.
- Each edge samples the pair (anode, cathode). A pair is valid only if exactly one anode bit is low. All-high (blanking) and multiple-low pairs are invalid.
- Stability counter: if the pair is valid and equal to the previous edge's pair, the counter increments and saturates at STABLE_CYCLES. Otherwise it reloads to 1 for a valid pair or 0 for an invalid pair.
- Capture: on the edge where the counter first reaches STABLE_CYCLES, the decoded nibble, dp and error bit are written to shadow slot k, and seen[k] is set. While the pair stays unchanged, no further capture happens.
- A digit captured again before the frame completes overwrites its slot.
- Frame completion: when a capture makes seen all ones, on that same edge:
  - shadow is copied to value, dp_out and digit_err;
  - frame_valid is asserted for the following cycle only;
  - seen is cleared.
- Outputs hold between frames.
- FSM states:
  - IDLE: counter 0, no valid pair.
  - TRACK: valid pair, counter below STABLE_CYCLES.
  - HOLD: captured; waiting for the pair to change.
  - Any pair change returns to TRACK (valid pair) or IDLE (invalid pair).

## Timing
- Reset (rst_n low at an edge): value=0, dp_out=0, digit_err=0, frame_valid=0, seen=0, counter=0, state IDLE. Reset overrides all activity, including a capture due on the same edge.
- Reset mid-frame discards partial shadow data. A complete fresh frame is required afterwards.
- Capture latency: a pair first sampled at edge n is captured at edge n+STABLE_CYCLES-1.
- frame_valid is high in the cycle after the final capture edge, and never for two consecutive cycles.
- A pair held for STABLE_CYCLES-1 edges and then changed produces no capture.
- With STABLE_CYCLES=1, every new valid pair captures on its first sample.
- The counter width is clog2(STABLE_CYCLES+1). It never wraps.

## Structure
- Shared package sseg_pkg holds:
  - segment bit-index constants (SEG_A..SEG_DP);
  - the 16-entry glyph constant array;
  - a function hex_to_sseg, shared with the existing decoder.
- Sub-module sseg_to_hex: purely combinational. Input cathode[6:0]; outputs nibble[3:0] and illegal. Instantiated once.
- Top level: input sample registers, stability counter and FSM, shadow slots, seen mask, output registers.

## Test plan
- Reset: hold rst_n=0 for 2 edges with arbitrary inputs → value=0, dp_out=0, digit_err=0, frame_valid=0.
- Full frame: anode 1110/66, 1101/4F, 1011/5B, 0111/06, each held 8 cycles → value=16'h1234, digit_err=0, exactly one frame_valid pulse.
- Glitch rejection: anode 1110 with 3F held 3 cycles (STABLE_CYCLES=4), then 7F held 8 cycles → slot 0 = 8, never 0.
- Illegal glyph and dp: digit 2 shows 49 and digit 0 shows DB in an otherwise legal frame → digit_err=0100, value[11:8]=0, value[3:0]=2, dp_out=0001.
- Blanking and multi-select: anode 1111 or 1100 for 20 cycles between digits → no capture; the frame still completes correctly afterwards.
- Reset mid-frame: capture digits 0 and 1, pulse rst_n low, then scan digits 2 and 3 only → no frame_valid and value stays 0 until all four digits are rescanned.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions.
// Holds the segment bit indices, the hex glyph table and the hex-to-pattern
// helper used by both the display decoder and the scan capture readback.
// Also defines the scan capture FSM state type.
package sseg_pkg;

    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    // Active-high patterns, bit order {g,f,e,d,c,b,a}, indexed by hex value.
    localparam logic [6:0] GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex_to_sseg(input logic [3:0] hex);
        return GLYPHS[hex];
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HOLD
    } scan_state_e;

endpackage

// File: rtl/sseg_scan_capture_if.sv
// Display bus plus readback outputs of the scan capture block.
//   anode       : active-low digit selects (driven by the display scanner)
//   cathode     : active-high segments {dp,g,f,e,d,c,b,a}
//   value       : recovered frame, digit k at [4k+3:4k]
//   dp_out      : per-digit decimal point
//   digit_err   : per-digit illegal glyph flag
//   frame_valid : one-cycle pulse when the outputs above were refreshed
// master drives the display side, slave is the capture block.
interface sseg_scan_capture_if #(
    parameter int unsigned DIGITS = 4
);
    logic [DIGITS-1:0]   anode;
    logic [7:0]          cathode;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_out;
    logic [DIGITS-1:0]   digit_err;
    logic                frame_valid;

    modport master (
        output anode, cathode,
        input  value, dp_out, digit_err, frame_valid
    );

    modport slave (
        input  anode, cathode,
        output value, dp_out, digit_err, frame_valid
    );
endinterface

// File: rtl/sseg_to_hex.sv
// Inverse glyph lookup: maps a seven-segment pattern back to its hex nibble.
//   cathode : segment pattern {g,f,e,d,c,b,a}, active high
//   nibble  : decoded value, 0 when the pattern is not a hex glyph
//   illegal : 1 when the pattern matches no glyph
// Purely combinational.
module sseg_to_hex
    import sseg_pkg::*;
(
    input  logic [6:0] cathode,
    output logic [3:0] nibble,
    output logic       illegal
);

    always_comb begin
        nibble  = 4'h0;
        illegal = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (cathode == hex_to_sseg(4'(i))) begin
                nibble  = 4'(i);
                illegal = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sseg_scan_capture.sv
// Seven-segment scan readback.
// Watches the multiplexed display bus, waits for each digit's (anode, cathode)
// pair to be stable for STABLE_CYCLES edges, decodes it into a shadow slot and
// publishes the whole frame once every digit has been captured.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of sseg_scan_capture_if (display inputs, frame outputs)
module sseg_scan_capture
    import sseg_pkg::*;
#(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sseg_scan_capture_if.slave   bus
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] STABLE = CW'(STABLE_CYCLES);

    // Pair sampled on the previous edge, for the stability comparison.
    logic [DIGITS-1:0]   prev_anode;
    logic [7:0]          prev_cathode;
    logic [CW-1:0]       count;
    scan_state_e         state;
    logic [DIGITS-1:0]   seen;

    logic [3:0]          shadow_nib [DIGITS];
    logic [DIGITS-1:0]   shadow_dp;
    logic [DIGITS-1:0]   shadow_err;

    logic [4*DIGITS-1:0] value_q;
    logic [DIGITS-1:0]   dp_q;
    logic [DIGITS-1:0]   err_q;
    logic                frame_valid_q;

    // Combinational decode of the current pair.
    logic [3:0]          nibble;
    logic                illegal;
    logic                sel_valid;
    logic [IW-1:0]       sel_idx;
    logic                same_pair;
    logic [CW-1:0]       count_next;
    logic                capture;
    logic [DIGITS-1:0]   seen_next;
    logic                frame_done;

    sseg_to_hex u_sseg_to_hex (
        .cathode (bus.cathode[6:0]),
        .nibble  (nibble),
        .illegal (illegal)
    );

    always_comb begin
        int unsigned nlow;
        nlow    = 0;
        sel_idx = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (!bus.anode[k]) begin
                nlow    = nlow + 1;
                sel_idx = IW'(k);
            end
        end
        sel_valid = (nlow == 1);
    end

    always_comb begin
        same_pair = sel_valid && (bus.anode == prev_anode) && (bus.cathode == prev_cathode);

        if (!sel_valid) begin
            count_next = '0;
        end else if (same_pair) begin
            count_next = (count == STABLE) ? STABLE : count + 1'b1;
        end else begin
            count_next = CW'(1);
        end

        // Capture only on the edge the count first reaches STABLE; an unchanged
        // pair already in HOLD must not capture again.
        capture    = sel_valid && (count_next == STABLE) && !(same_pair && state == HOLD);
        seen_next  = capture ? (seen | ~bus.anode) : seen;
        frame_done = capture && (&seen_next);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_anode    <= '1;
            prev_cathode  <= '0;
            count         <= '0;
            state         <= IDLE;
            seen          <= '0;
            shadow_dp     <= '0;
            shadow_err    <= '0;
            for (int k = 0; k < DIGITS; k++) begin
                shadow_nib[k] <= 4'h0;
            end
            value_q       <= '0;
            dp_q          <= '0;
            err_q         <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            prev_anode   <= bus.anode;
            prev_cathode <= bus.cathode;
            count        <= count_next;

            if (!sel_valid) begin
                state <= IDLE;
            end else if (count_next == STABLE) begin
                state <= HOLD;
            end else begin
                state <= TRACK;
            end

            if (capture) begin
                shadow_nib[sel_idx] <= nibble;
                shadow_dp[sel_idx]  <= bus.cathode[SEG_DP];
                shadow_err[sel_idx] <= illegal;
            end

            frame_valid_q <= frame_done;

            if (frame_done) begin
                seen <= '0;
                // Final digit bypasses its shadow slot so it lands on this edge.
                for (int k = 0; k < DIGITS; k++) begin
                    if (IW'(k) == sel_idx) begin
                        value_q[4*k +: 4] <= nibble;
                        dp_q[k]           <= bus.cathode[SEG_DP];
                        err_q[k]          <= illegal;
                    end else begin
                        value_q[4*k +: 4] <= shadow_nib[k];
                        dp_q[k]           <= shadow_dp[k];
                        err_q[k]          <= shadow_err[k];
                    end
                end
            end else begin
                seen <= seen_next;
            end
        end
    end

    assign bus.value       = value_q;
    assign bus.dp_out      = dp_q;
    assign bus.digit_err   = err_q;
    assign bus.frame_valid = frame_valid_q;

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Directed bench for sseg_scan_capture (DIGITS=4, STABLE_CYCLES=4).
module tb_sseg_scan_capture;

    logic clk;
    logic rst_n;

    sseg_scan_capture_if #(.DIGITS(4)) bus ();

    sseg_scan_capture #(
        .DIGITS        (4),
        .STABLE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Pulse monitor, sampled on the falling edge.
    int fv_count  = 0;
    bit fv_prev   = 1'b0;
    bit fv_double = 1'b0;
    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) fv_count++;
        if (bus.frame_valid === 1'b1 && fv_prev) fv_double = 1'b1;
        fv_prev = (bus.frame_valid === 1'b1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input logic [3:0] an, input logic [7:0] ca, input int n);
        bus.anode   = an;
        bus.cathode = ca;
        step(n);
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.anode   = 4'b1110;
        bus.cathode = 8'h66;
        step(2);
        total++;
        if (bus.value !== 16'h0) $display("FAIL reset_value: got %h expected 0000", bus.value);
        else passed++;
        total++;
        if (bus.dp_out !== 4'h0) $display("FAIL reset_dp: got %b expected 0000", bus.dp_out);
        else passed++;
        total++;
        if (bus.digit_err !== 4'h0) $display("FAIL reset_err: got %b expected 0000", bus.digit_err);
        else passed++;
        total++;
        if (bus.frame_valid !== 1'b0) $display("FAIL reset_fv: got %b expected 0", bus.frame_valid);
        else passed++;
        rst_n = 1'b1;
        show(4'b1111, 8'h00, 2);
    endtask

    task automatic test_full_frame();
        int base;
        base = fv_count;
        show(4'b1110, 8'h66, 8);
        show(4'b1101, 8'h4F, 8);
        show(4'b1011, 8'h5B, 8);
        show(4'b0111, 8'h06, 8);
        show(4'b1111, 8'h00, 2);
        total++;
        if (bus.value !== 16'h1234) $display("FAIL full_value: got %h expected 1234", bus.value);
        else passed++;
        total++;
        if (bus.digit_err !== 4'h0) $display("FAIL full_err: got %b expected 0000", bus.digit_err);
        else passed++;
        total++;
        if (bus.dp_out !== 4'h0) $display("FAIL full_dp: got %b expected 0000", bus.dp_out);
        else passed++;
        total++;
        if (fv_count - base !== 1) $display("FAIL full_pulses: got %0d expected 1", fv_count - base);
        else passed++;
    endtask

    task automatic test_glitch();
        int base;
        base = fv_count;
        show(4'b1110, 8'h3F, 3);
        show(4'b1110, 8'h7F, 8);
        show(4'b1101, 8'h06, 8);
        show(4'b1011, 8'h06, 8);
        show(4'b0111, 8'h06, 8);
        show(4'b1111, 8'h00, 2);
        check16("glitch_value", bus.value, 16'h1118);
        total++;
        if (fv_count - base !== 1) $display("FAIL glitch_pulses: got %0d expected 1", fv_count - base);
        else passed++;
    endtask

    task automatic test_illegal_dp();
        show(4'b1110, 8'hDB, 8);
        show(4'b1101, 8'h06, 8);
        show(4'b1011, 8'h49, 8);
        show(4'b0111, 8'h06, 8);
        show(4'b1111, 8'h00, 2);
        check16("illegal_value", bus.value, 16'h1012);
        total++;
        if (bus.digit_err !== 4'b0100) $display("FAIL illegal_err: got %b expected 0100", bus.digit_err);
        else passed++;
        total++;
        if (bus.dp_out !== 4'b0001) $display("FAIL illegal_dp: got %b expected 0001", bus.dp_out);
        else passed++;
        total++;
        if (bus.value[11:8] !== 4'h0) $display("FAIL illegal_nib: got %h expected 0", bus.value[11:8]);
        else passed++;
    endtask

    task automatic test_blanking();
        int base;
        base = fv_count;
        show(4'b1110, 8'h3F, 8);
        show(4'b1111, 8'h7F, 20);
        show(4'b1101, 8'h06, 8);
        show(4'b1100, 8'h5B, 20);
        show(4'b1011, 8'h5B, 8);
        show(4'b1111, 8'h00, 20);
        total++;
        if (fv_count - base !== 0) $display("FAIL blank_early: got %0d expected 0", fv_count - base);
        else passed++;
        show(4'b0111, 8'h4F, 8);
        show(4'b1111, 8'h00, 2);
        check16("blank_value", bus.value, 16'h3210);
        total++;
        if (fv_count - base !== 1) $display("FAIL blank_pulses: got %0d expected 1", fv_count - base);
        else passed++;
    endtask

    task automatic test_latency();
        int base;
        base = fv_count;
        show(4'b1101, 8'h06, 8);
        show(4'b1011, 8'h06, 8);
        show(4'b0111, 8'h06, 8);
        // Held one edge short of STABLE_CYCLES: must not capture.
        show(4'b1110, 8'h3F, 3);
        show(4'b1111, 8'h00, 2);
        total++;
        if (fv_count - base !== 0) $display("FAIL short_hold: got %0d expected 0", fv_count - base);
        else passed++;
        show(4'b1110, 8'h3F, 3);
        total++;
        if (bus.frame_valid !== 1'b0) $display("FAIL lat_early: got %b expected 0", bus.frame_valid);
        else passed++;
        step(1);
        total++;
        if (bus.frame_valid !== 1'b1) $display("FAIL lat_edge: got %b expected 1", bus.frame_valid);
        else passed++;
        check16("lat_value", bus.value, 16'h1110);
        step(1);
        total++;
        if (bus.frame_valid !== 1'b0) $display("FAIL lat_single: got %b expected 0", bus.frame_valid);
        else passed++;
        show(4'b1111, 8'h00, 2);
    endtask

    task automatic test_reset_mid();
        int base;
        show(4'b1110, 8'h7D, 8);
        show(4'b1101, 8'h6D, 8);
        show(4'b1111, 8'h00, 1);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check16("mid_reset_value", bus.value, 16'h0000);
        base = fv_count;
        show(4'b1011, 8'h66, 8);
        show(4'b0111, 8'h07, 8);
        show(4'b1111, 8'h00, 2);
        total++;
        if (fv_count - base !== 0) $display("FAIL mid_partial: got %0d expected 0", fv_count - base);
        else passed++;
        check16("mid_partial_value", bus.value, 16'h0000);
        show(4'b1110, 8'h7D, 8);
        show(4'b1101, 8'h6D, 8);
        show(4'b1111, 8'h00, 2);
        total++;
        if (fv_count - base !== 1) $display("FAIL mid_pulses: got %0d expected 1", fv_count - base);
        else passed++;
        check16("mid_value", bus.value, 16'h7456);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_glitch();
        test_illegal_dp();
        test_blanking();
        test_latency();
        test_reset_mid();
        total++;
        if (fv_double !== 1'b0) $display("FAIL fv_double: got %b expected 0", fv_double);
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
